// File: rtl/gpr_wport_arbiter.sv
// Arbitrates the single GPR write port between the writeback stage (W) and a
// buffered multi-cycle result source (M) with a starvation guard for M.
module gpr_wport_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNTW     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       w_we,
    input  logic [4:0]                 w_addr,
    input  logic [31:0]                w_data,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [4:0]                 m_addr,
    input  logic [31:0]                m_data,
    output logic                       stall_w,
    output logic                       gpr_we,
    output logic [4:0]                 gpr_a3,
    output logic [31:0]                gpr_wd,
    output logic [31:0]                pend_mask,
    output logic [$clog2(DEPTH+1)-1:0] fifo_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [4:0]      addr_q  [DEPTH];
    logic [4:0]      addr_d  [DEPTH];
    logic [31:0]     data_q  [DEPTH];
    logic [31:0]     data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CNTW-1:0] wait_cnt_q, wait_cnt_d;

    logic w_req, head_v, grant_m, grant_w, push, pop;

    // Gating with reset keeps the port silent while reset is held low.
    assign w_req    = reset & w_we & (w_addr != 5'd0);
    assign head_v   = (count_q != '0);
    assign grant_m  = head_v & (~w_req | (wait_cnt_q == CNTW'(MAX_WAIT)));
    assign grant_w  = ~grant_m & w_req;
    assign m_ready  = reset & (count_q < CW'(DEPTH));
    assign push     = m_valid & m_ready & (m_addr != 5'd0);
    assign pop      = grant_m;
    assign fifo_cnt = count_q;

    always_comb begin
        gpr_we  = 1'b0;
        gpr_a3  = 5'd0;
        gpr_wd  = 32'd0;
        stall_w = 1'b0;
        if (grant_m) begin
            gpr_we  = 1'b1;
            gpr_a3  = addr_q[rd_ptr_q];
            gpr_wd  = data_q[rd_ptr_q];
            stall_w = w_req;
        end else if (grant_w) begin
            gpr_we = 1'b1;
            gpr_a3 = w_addr;
            gpr_wd = w_data;
        end
    end

    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pend_mask[addr_q[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q]  = m_addr;
            data_d[wr_ptr_q]  = m_data;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (grant_m || !head_v) begin
            wait_cnt_d = '0;
        end else if (grant_w && (wait_cnt_q != CNTW'(MAX_WAIT))) begin
            wait_cnt_d = wait_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
            end
            valid_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_gpr_wport_arbiter.sv
// Self-checking bench for gpr_wport_arbiter: per-scenario inline checks plus a
// scoreboard of the ordered GPR writes.
module tb_gpr_wport_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        stall_w;
    logic        gpr_we;
    logic [4:0]  gpr_a3;
    logic [31:0] gpr_wd;
    logic [31:0] pend_mask;
    logic [1:0]  fifo_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    logic [36:0] m_q[$];    // accepted M results awaiting their write
    logic [36:0] exp_q[$];  // expected write order
    logic [36:0] obs_q[$];  // observed writes

    gpr_wport_arbiter #(.DEPTH(2), .MAX_WAIT(4), .CNTW(3)) dut (
        .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
        .stall_w(stall_w), .gpr_we(gpr_we), .gpr_a3(gpr_a3), .gpr_wd(gpr_wd),
        .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gpr_we === 1'b1) obs_q.push_back({gpr_a3, gpr_wd});
    end

    function automatic logic [31:0] wd(input int k);
        return 32'hA000_0000 | k;
    endfunction

    task automatic test_reset();
        reset = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (m_ready !== 1'b0 || gpr_we !== 1'b0 || fifo_cnt !== 2'd0) begin
            n_fails++;
            $display("FAIL reset_hold: m_ready=%b gpr_we=%b cnt=%0d want 0 0 0",
                     m_ready, gpr_we, fifo_cnt);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_ready !== 1'b1 || gpr_we !== 1'b0 || pend_mask !== 32'd0 || stall_w !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release: m_ready=%b gpr_we=%b pend=%h stall=%b want 1 0 0 0",
                     m_ready, gpr_we, pend_mask, stall_w);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_filter();
        w_we = 1'b1; w_addr = 5'd0; w_data = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if (gpr_we !== 1'b0) begin
            n_fails++;
            $display("FAIL w_zero: gpr_we=%b want 0", gpr_we);
        end
        @(posedge clk); #1 w_we = 1'b0;
        m_valid = 1'b1; m_addr = 5'd0; m_data = 32'hCAFE_0000;
        @(negedge clk);
        n_checks++;
        if (m_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL m_zero_ready: m_ready=%b want 1", m_ready);
        end
        @(posedge clk); #1 m_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fifo_cnt !== 2'd0 || gpr_we !== 1'b0) begin
            n_fails++;
            $display("FAIL m_zero_drop: cnt=%0d gpr_we=%b want 0 0", fifo_cnt, gpr_we);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_m_latency();
        m_valid = 1'b1; m_addr = 5'd5; m_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (gpr_we !== 1'b0) begin
            n_fails++;
            $display("FAIL no_fallthrough: gpr_we=%b want 0", gpr_we);
        end
        m_q.push_back({5'd5, 32'hDEAD_BEEF});
        @(posedge clk); #1 m_valid = 1'b0;
        @(negedge clk);
        exp_q.push_back(m_q.pop_front());
        n_checks++;
        if (gpr_we !== 1'b1 || gpr_a3 !== 5'd5 || gpr_wd !== 32'hDEAD_BEEF
            || pend_mask !== 32'h20) begin
            n_fails++;
            $display("FAIL m_latency: we=%b a3=%0d wd=%h pend=%h want 1 5 deadbeef 20",
                     gpr_we, gpr_a3, gpr_wd, pend_mask);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (pend_mask !== 32'd0 || gpr_we !== 1'b0) begin
            n_fails++;
            $display("FAIL m_after: pend=%h we=%b want 0 0", pend_mask, gpr_we);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_starvation();
        int wa = 8;
        m_valid = 1'b1; m_addr = 5'd7; m_data = 32'h11;
        m_q.push_back({5'd7, 32'h11});
        @(posedge clk); #1 m_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            logic exp_stall;
            w_we = 1'b1; w_addr = 5'(wa); w_data = wd(wa);
            exp_stall = (c == 5);
            @(negedge clk);
            if (exp_stall) exp_q.push_back(m_q.pop_front());
            else           exp_q.push_back({5'(wa), wd(wa)});
            n_checks++;
            if (stall_w !== exp_stall || gpr_we !== 1'b1) begin
                n_fails++;
                $display("FAIL starve_c%0d: stall=%b we=%b want %b 1",
                         c, stall_w, gpr_we, exp_stall);
            end
            @(posedge clk); #1;
            if (!exp_stall) wa++;
        end
        w_we = 1'b0;
    endtask

    task automatic test_full_fifo();
        w_we = 1'b1; w_addr = 5'd16; w_data = wd(16);
        m_valid = 1'b1; m_addr = 5'd1; m_data = 32'hAAAA_0001;
        @(negedge clk);
        exp_q.push_back({5'd16, wd(16)});
        m_q.push_back({5'd1, 32'hAAAA_0001});
        @(posedge clk); #1 w_addr = 5'd17; w_data = wd(17);
        m_addr = 5'd2; m_data = 32'hBBBB_0002;
        @(negedge clk);
        exp_q.push_back({5'd17, wd(17)});
        m_q.push_back({5'd2, 32'hBBBB_0002});
        @(posedge clk); #1 m_addr = 5'd4; m_data = 32'hDDDD_0004;
        for (int k = 18; k <= 20; k++) begin
            w_addr = 5'(k); w_data = wd(k);
            @(negedge clk);
            exp_q.push_back({5'(k), wd(k)});
            n_checks++;
            if (fifo_cnt !== 2'd2 || m_ready !== 1'b0 || pend_mask !== 32'h6) begin
                n_fails++;
                $display("FAIL full_%0d: cnt=%0d ready=%b pend=%h want 2 0 6",
                         k, fifo_cnt, m_ready, pend_mask);
            end
            @(posedge clk); #1;
        end
        w_addr = 5'd21; w_data = wd(21);
        @(negedge clk);
        exp_q.push_back(m_q.pop_front());
        n_checks++;
        if (stall_w !== 1'b1 || m_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL full_force: stall=%b ready=%b want 1 0", stall_w, m_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        exp_q.push_back({5'd21, wd(21)});
        m_q.push_back({5'd4, 32'hDDDD_0004});
        n_checks++;
        if (m_ready !== 1'b1 || stall_w !== 1'b0) begin
            n_fails++;
            $display("FAIL full_reopen: ready=%b stall=%b want 1 0", m_ready, stall_w);
        end
        @(posedge clk); #1 m_valid = 1'b0; w_we = 1'b0;
        for (int k = 2; k >= 1; k--) begin
            @(negedge clk);
            exp_q.push_back(m_q.pop_front());
            n_checks++;
            if (fifo_cnt !== 2'(k)) begin
                n_fails++;
                $display("FAIL full_drain_cnt: cnt=%0d want %0d", fifo_cnt, k);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_push_pop();
        m_valid = 1'b1; m_addr = 5'd9; m_data = 32'hEEEE_0009;
        m_q.push_back({5'd9, 32'hEEEE_0009});
        @(posedge clk); #1 m_addr = 5'd3; m_data = 32'hCCCC_0003;
        @(negedge clk);
        exp_q.push_back(m_q.pop_front());
        m_q.push_back({5'd3, 32'hCCCC_0003});
        n_checks++;
        if (fifo_cnt !== 2'd1) begin
            n_fails++;
            $display("FAIL pp_before: cnt=%0d want 1", fifo_cnt);
        end
        @(posedge clk); #1 m_valid = 1'b0;
        @(negedge clk);
        exp_q.push_back(m_q.pop_front());
        n_checks++;
        if (fifo_cnt !== 2'd1 || pend_mask !== 32'h8) begin
            n_fails++;
            $display("FAIL pp_after: cnt=%0d pend=%h want 1 8", fifo_cnt, pend_mask);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        w_we = 1'b1; w_addr = 5'd22; w_data = wd(22);
        m_valid = 1'b1; m_addr = 5'd6; m_data = 32'h6666_0006;
        @(negedge clk);
        exp_q.push_back({5'd22, wd(22)});
        @(posedge clk); #1 w_addr = 5'd23; w_data = wd(23);
        m_addr = 5'd10; m_data = 32'h1010_000A;
        @(negedge clk);
        exp_q.push_back({5'd23, wd(23)});
        @(posedge clk); #1 m_valid = 1'b0; w_addr = 5'd24; w_data = wd(24);
        @(negedge clk);
        exp_q.push_back({5'd24, wd(24)});
        n_checks++;
        if (fifo_cnt !== 2'd2) begin
            n_fails++;
            $display("FAIL ar_fill: cnt=%0d want 2", fifo_cnt);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (gpr_we !== 1'b0 || pend_mask !== 32'd0 || fifo_cnt !== 2'd0 || m_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL ar_immediate: we=%b pend=%h cnt=%0d ready=%b want 0 0 0 0",
                     gpr_we, pend_mask, fifo_cnt, m_ready);
        end
        w_we = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (gpr_we !== 1'b0 || fifo_cnt !== 2'd0) begin
                n_fails++;
                $display("FAIL ar_stale_%0d: we=%b cnt=%0d want 0 0", c, gpr_we, fifo_cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_scoreboard();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL sb_count: observed %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fails++;
                $display("FAIL sb_write_%0d: a3=%0d wd=%h want a3=%0d wd=%h", i,
                         obs_q[i][36:32], obs_q[i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_filter();
        test_m_latency();
        test_starvation();
        test_full_fifo();
        test_push_pop();
        test_async_reset();
        test_scoreboard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
